// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM and grant encodings, IO window default and round-robin pick helper shared by mem_arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic {GNT_IF = 1'b0, GNT_D = 1'b1} grant_t;
  localparam int IO_BIT_DEF = 22;
  // On contention the port that was not granted last time wins; a lone requester always wins.
  function automatic grant_t mem_arb_pick(input logic if_req, input logic d_req, input grant_t last_grant);
    return (if_req && d_req) ? ((last_grant == GNT_D) ? GNT_IF : GNT_D) : (d_req ? GNT_D : GNT_IF);
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port, RAM port and IO port of the memory arbiter.
//   master: the arbiter (drives acks, rdata, mem_* and io_* requests)
//   slave : the core, RAM and IO side (drives reqs, addresses, write data, mem_rdata, io_rdata)
interface mem_arbiter_if #(parameter int ADDR_WIDTH = 8);
  logic                  if_req;
  logic [31:0]           if_addr;
  logic [31:0]           if_rdata;
  logic                  if_ack;
  logic                  d_req;
  logic [31:0]           d_addr;
  logic [3:0]            d_wmask;
  logic [31:0]           d_wdata;
  logic [31:0]           d_rdata;
  logic                  d_ack;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rden;
  logic [3:0]            mem_wmask;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic [19:0]           io_addr;
  logic                  io_rstrb;
  logic                  io_wstrb;
  logic [31:0]           io_wdata;
  logic [31:0]           io_rdata;
  modport master (
    input  if_req, if_addr, d_req, d_addr, d_wmask, d_wdata, mem_rdata, io_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, mem_addr, mem_rden, mem_wmask, mem_wdata,
           io_addr, io_rstrb, io_wstrb, io_wdata
  );
  modport slave (
    output if_req, if_addr, d_req, d_addr, d_wmask, d_wdata, mem_rdata, io_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_addr, mem_rden, mem_wmask, mem_wdata,
           io_addr, io_rstrb, io_wstrb, io_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM and the IO window between the fetch and data ports via IDLE/ACCESS/RESP.
//   clk    : clock
//   resetn : synchronous active-low reset
//   bus    : mem_arbiter_if.master (fetch/data req-ack ports, RAM port, IO port)
//   MEM_ARB_RR_EN defined: round-robin on contention; undefined: data port has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int IO_BIT     = IO_BIT_DEF
) (
  input logic           clk,
  input logic           resetn,
  mem_arbiter_if.master bus
);
  state_t                r_state, w_next;
  grant_t                r_grant, w_grant;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [19:0]           r_io_addr;
  logic                  r_io;
  logic [3:0]            r_wmask;
  logic [31:0]           r_wdata, r_io_q, r_if_rdata, r_d_rdata, w_rdata, w_addr;
  logic                  w_rd, w_start, w_unused;
  assign w_start = (r_state == IDLE) && (bus.if_req || bus.d_req);
`ifdef MEM_ARB_RR_EN
  grant_t r_last_grant;
  assign w_grant = mem_arb_pick(bus.if_req, bus.d_req, r_last_grant);
  always_ff @(posedge clk) begin
    if (!resetn) r_last_grant <= GNT_IF;
    else if (w_start) r_last_grant <= w_grant;
  end
`else
  assign w_grant = bus.d_req ? GNT_D : GNT_IF;
`endif
  assign w_addr   = (w_grant == GNT_D) ? bus.d_addr : bus.if_addr;
  // Upper RAM address bits alias and addr[1:0] is ignored, so most address bits are intentionally dropped.
  assign w_unused = &{1'b0, w_addr};
  assign w_rd     = (r_wmask == 4'd0);
  // Write acks return zero; reads take the IO snapshot or the registered RAM word.
  assign w_rdata  = !w_rd ? 32'd0 : r_io ? r_io_q : bus.mem_rdata;
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_grant    <= GNT_IF;
      r_ram_addr <= '0;
      r_io_addr  <= '0;
      r_io       <= 1'b0;
      r_wmask    <= 4'd0;
      r_wdata    <= '0;
      r_io_q     <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_start) begin
        r_grant    <= w_grant;
        r_ram_addr <= w_addr[ADDR_WIDTH+1:2];
        r_io_addr  <= w_addr[21:2];
        r_io       <= w_addr[IO_BIT];
        r_wmask    <= (w_grant == GNT_D) ? bus.d_wmask : 4'd0;
        r_wdata    <= bus.d_wdata;
      end
      if (bus.io_rstrb) r_io_q <= bus.io_rdata;
      if (bus.if_ack) r_if_rdata <= w_rdata;
      if (bus.d_ack) r_d_rdata <= w_rdata;
    end
  end
  always_comb begin
    w_next        = IDLE;
    bus.mem_addr  = r_ram_addr;
    bus.mem_wdata = r_wdata;
    bus.io_addr   = r_io_addr;
    bus.io_wdata  = r_wdata;
    bus.mem_rden  = 1'b0;
    bus.mem_wmask = 4'd0;
    bus.io_rstrb  = 1'b0;
    bus.io_wstrb  = 1'b0;
    bus.if_ack    = 1'b0;
    bus.d_ack     = 1'b0;
    bus.if_rdata  = r_if_rdata;
    bus.d_rdata   = r_d_rdata;
    case (r_state)
      IDLE: w_next = w_start ? ACCESS : IDLE;
      ACCESS: begin
        w_next        = RESP;
        bus.mem_rden  = !r_io && w_rd;
        bus.mem_wmask = r_io ? 4'd0 : r_wmask;
        bus.io_rstrb  = r_io && w_rd;
        bus.io_wstrb  = r_io && !w_rd;
      end
      RESP: begin
        bus.if_ack   = (r_grant == GNT_IF);
        bus.d_ack    = (r_grant == GNT_D);
        bus.if_rdata = (r_grant == GNT_IF) ? w_rdata : r_if_rdata;
        bus.d_rdata  = (r_grant == GNT_D) ? w_rdata : r_d_rdata;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port word memory, plus the memory-mapped IO window, between the CPU instruction-fetch port and the load/store data port.
- Sits between the multi-cycle RV32I core and the SOC block RAM / IO peripherals (LEDs, UART).
- Sequences each access through a 3-state FSM with a req/ack handshake per port.
- Arbitrates with fixed data-port priority, or optionally round-robin.

Parameters:
- ADDR_WIDTH, 8, word-address width of the RAM (256 words).
- IO_BIT, 22, byte-address bit that selects the IO window when 1.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  32  fetch byte address; word aligned
- if_rdata  out  32  fetch data; valid when if_ack=1
- if_ack  out  1  one-cycle completion pulse
- d_req  in  1  data request; held until d_ack
- d_addr  in  32  data byte address
- d_wmask  in  4  byte write enables; 0 = read
- d_wdata  in  32  write data, byte-lane aligned
- d_rdata  out  32  load data; valid when d_ack=1
- d_ack  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_WIDTH  RAM word address
- mem_rden  out  1  RAM read strobe
- mem_wmask  out  4  RAM byte write enables
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data; registered, valid the cycle after mem_rden
- io_addr  out  20  IO word address (byte addr[21:2])
- io_rstrb  out  1  IO read strobe
- io_wstrb  out  1  IO write strobe
- io_wdata  out  32  IO write data
- io_rdata  in  32  IO read data; combinational, valid while io_rstrb=1

Behaviour:
- Reset: resetn is synchronous, active-low, clock is clk. On reset: state=IDLE, grant=IF, last_grant=IF; all acks, strobes, mem_wmask = 0; rdata outputs = 0.
- Reset mid-transaction aborts it with no ack. A RAM write already strobed may complete.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req, register the grant, address, mask, wdata and region (addr[IO_BIT]), then go to ACCESS. Otherwise stay.
- ACCESS (exactly one cycle), RAM region:
  - mem_addr = addr[ADDR_WIDTH+1:2].
  - mem_rden = (wmask==0).
  - mem_wmask = wmask, gated to 0 for fetch.
- ACCESS, IO region:
  - io_rstrb = (wmask==0); io_wstrb = (wmask!=0).
  - io_rdata is captured into io_q.
- All mem_* and io_* strobes are 0 outside ACCESS.
- RESP (exactly one cycle):
  - Granted port's ack = 1; rdata = region ? io_q : mem_rdata.
  - Write acks return rdata = 0.
  - Non-granted port's ack = 0. Next state is IDLE.
- Latency: req sampled high in IDLE at cycle N → ACCESS N+1 → ack N+2. Throughput is 1 access per 3 cycles.
- Requester rules:
  - Drop req on the edge that samples ack, or keep it high with new address/data to issue the next access.
  - Inputs are ignored outside IDLE; the latched copies are used.
- Fixed priority (default): d_req beats if_req when both are high in IDLE.
- Fetches never write. Addresses above RAM size alias (upper bits dropped). addr[1:0] is ignored.
- Port rdata holds its last acked value until the next ack on that port.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin. When both ports request in IDLE, grant the port that was not last_grant. last_grant updates on each grant.
- Undefined: fixed data priority, last_grant unused. Single-requester behaviour is identical in both modes.

Decomposition:
- Shared package mem_arb_pkg:
  - FSM state encoding (IDLE=0, ACCESS=1, RESP=2).
  - Grant encoding (GNT_IF=0, GNT_D=1).
  - IO_BIT default.
- No sub-module needed. Arbitration is an optional separate combinational mem_arb_pick (inputs: if_req, d_req, last_grant; output: grant). It is selected by MEM_ARB_RR_EN.

Test Plan:
- Fetch read: if_req=1, if_addr=0x0000_0008, RAM[2]=0x0050_0113 → mem_rden at N+1 with mem_addr=2; if_ack at N+2 with if_rdata=0x0050_0113; d_ack stays 0.
- Byte store: d_req, d_addr=0x0000_0011, d_wmask=4'b0010, d_wdata=0x0000_AB00 → mem_wmask=0010 and mem_addr=4 in ACCESS; d_ack at N+2; only byte 1 of RAM[4] changes.
- IO write/read: d_addr=0x0040_0004, wmask=4'b1111, wdata=5 → io_wstrb one cycle, io_addr=1, no mem strobe. A read with io_rdata=0x1234 → d_rdata=0x1234.
- Contention: if_req and d_req both high for 4 accesses.
  - Fixed mode: order is D,D,D,D, and if waits.
  - MEM_ARB_RR_EN: order is D,IF,D,IF.
- Reset abort: resetn=0 during ACCESS → next cycle IDLE, no ack either port, strobes 0. After release, a pending if_req is served with ack at +2.
- Back-to-back: d_req held with a new address on the ack edge → next ack exactly 3 cycles later; if_req low gives no spurious if_ack.
